// File: rtl/execute_unit_if.sv
// rtl/execute_unit_if.sv - decoded-operation and result handshake bundle for execute_unit
//
// Ports grouped here:
//   in_valid/in_ready      issue handshake from the decoder
//   operation/rd/rs1_val/rs2_val/imm  decoded operation payload
//   out_valid/out_ready    result handshake toward memory/writeback
//   out_op/out_rd/out_result/out_store_data/out_illegal  result payload
//   busy                   division in progress
// Modports: master = decoder/writeback side, slave = execute_unit.
interface execute_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  operation;
  logic [4:0]  rd;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [11:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_op;
  logic [4:0]  out_rd;
  logic [31:0] out_result;
  logic [31:0] out_store_data;
  logic        out_illegal;
  logic        busy;

  modport master (
    output in_valid, operation, rd, rs1_val, rs2_val, imm, out_ready,
    input  in_ready, out_valid, out_op, out_rd, out_result, out_store_data,
           out_illegal, busy
  );

  modport slave (
    input  in_valid, operation, rd, rs1_val, rs2_val, imm, out_ready,
    output in_ready, out_valid, out_op, out_rd, out_result, out_store_data,
           out_illegal, busy
  );
endinterface

// File: rtl/execute_unit.sv
// rtl/execute_unit.sv - execute stage: 1-cycle ADD/SUB/MUL/LOAD/STORE, 32-cycle signed DIV
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  execute_unit_if.slave: issue handshake + operands in,
//        registered result handshake out, busy while dividing
module execute_unit (
  input  logic           clk,
  input  logic           rst,
  execute_unit_if.slave  bus
);
  localparam int XLEN = 32;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_MUL   = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_LOAD  = 4'd4;
  localparam logic [3:0] OP_STORE = 4'd5;

  typedef enum logic {IDLE, DIV_RUN} state_t;

  state_t            state, state_next;
  logic [4:0]        count;
  logic              accept, start_div, div_done;

  // Divider registers: div_quo starts as the dividend magnitude and is
  // shifted left each step, its top bit feeding the partial remainder while
  // quotient bits enter at the bottom.
  logic [XLEN-1:0]   div_rem, div_quo, div_mag;
  logic              div_neg, div_zero;
  logic [4:0]        div_rd;

  logic [XLEN:0]     rem_shift, rem_diff;
  logic [XLEN-1:0]   rem_next, quo_next, div_result;
  logic [XLEN-1:0]   rs1_mag, rs2_mag, imm_ext;
  logic [XLEN-1:0]   alu_result, alu_store;
  logic              alu_illegal;

  assign bus.in_ready = (state == IDLE) && (!bus.out_valid || bus.out_ready) && !rst;
  assign accept       = bus.in_valid && bus.in_ready;
  assign start_div    = accept && (bus.operation == OP_DIV);
  assign div_done     = (state == DIV_RUN) && (count == 5'd0);

  // FSM next state and outputs
  always_comb begin
    state_next = state;
    bus.busy   = 1'b0;
    case (state)
      IDLE: begin
        if (start_div) state_next = DIV_RUN;
      end
      DIV_RUN: begin
        bus.busy = 1'b1;
        if (count == 5'd0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Single-cycle operations
  always_comb begin
    imm_ext     = {{(XLEN-12){bus.imm[11]}}, bus.imm};
    alu_result  = '0;
    alu_store   = '0;
    alu_illegal = 1'b0;
    case (bus.operation)
      OP_ADD:   alu_result = bus.rs1_val + bus.rs2_val;
      OP_SUB:   alu_result = bus.rs1_val - bus.rs2_val;
      OP_MUL:   alu_result = bus.rs1_val * bus.rs2_val;
      OP_LOAD:  alu_result = bus.rs1_val + imm_ext;
      OP_STORE: begin
        alu_result = bus.rs1_val + imm_ext;
        alu_store  = bus.rs2_val;
      end
      OP_DIV:   alu_result = '0;
      default:  alu_illegal = 1'b1;
    endcase
  end

  // One restoring divide step. The remainder is always below the divisor
  // (at most 2^31), so the shifted value fits in 32 bits except for a zero
  // divisor, whose result is overridden anyway.
  always_comb begin
    rs1_mag   = bus.rs1_val[XLEN-1] ? -bus.rs1_val : bus.rs1_val;
    rs2_mag   = bus.rs2_val[XLEN-1] ? -bus.rs2_val : bus.rs2_val;
    rem_shift = {div_rem, div_quo[XLEN-1]};
    rem_diff  = rem_shift - {1'b0, div_mag};
    if (!rem_diff[XLEN]) begin
      rem_next = rem_diff[XLEN-1:0];
      quo_next = {div_quo[XLEN-2:0], 1'b1};
    end else begin
      rem_next = rem_shift[XLEN-1:0];
      quo_next = {div_quo[XLEN-2:0], 1'b0};
    end
    // 0x80000000 / -1 falls out naturally: magnitude 2^31 negates to itself.
    div_result = div_zero ? '1 : (div_neg ? -quo_next : quo_next);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= 5'd0;
      div_rem  <= '0;
      div_quo  <= '0;
      div_mag  <= '0;
      div_neg  <= 1'b0;
      div_zero <= 1'b0;
      div_rd   <= 5'd0;
    end else begin
      state <= state_next;
      if (start_div) begin
        count    <= 5'd31;
        div_rem  <= '0;
        div_quo  <= rs1_mag;
        div_mag  <= rs2_mag;
        div_neg  <= bus.rs1_val[XLEN-1] ^ bus.rs2_val[XLEN-1];
        div_zero <= (bus.rs2_val == '0);
        div_rd   <= bus.rd;
      end else if (state == DIV_RUN) begin
        count   <= count - 5'd1;
        div_rem <= rem_next;
        div_quo <= quo_next;
      end
    end
  end

  // Output register: drain first, then a load on the same edge overrides it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid      <= 1'b0;
      bus.out_op         <= 4'd0;
      bus.out_rd         <= 5'd0;
      bus.out_result     <= '0;
      bus.out_store_data <= '0;
      bus.out_illegal    <= 1'b0;
    end else begin
      if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;
      if (div_done) begin
        bus.out_valid      <= 1'b1;
        bus.out_op         <= OP_DIV;
        bus.out_rd         <= div_rd;
        bus.out_result     <= div_result;
        bus.out_store_data <= '0;
        bus.out_illegal    <= 1'b0;
      end else if (accept && (bus.operation != OP_DIV)) begin
        bus.out_valid      <= 1'b1;
        bus.out_op         <= bus.operation;
        bus.out_rd         <= bus.rd;
        bus.out_result     <= alu_result;
        bus.out_store_data <= alu_store;
        bus.out_illegal    <= alu_illegal;
      end
    end
  end
endmodule

// File: tb/tb_execute_unit.sv
// tb/tb_execute_unit.sv - self-checking bench for execute_unit
module tb_execute_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  execute_unit_if bus();
  execute_unit dut (.clk(clk), .rst(rst), .bus(bus));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_valid = 0, m_ill = 0;
  logic [3:0]  m_op = 0;
  logic [4:0]  m_rd = 0, p_rd = 0;
  logic [31:0] m_res = 0, m_sd = 0, p_res = 0;
  int          m_div_left = 0;

  task automatic calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [11:0] im, output logic [31:0] res,
                      output logic [31:0] sd, output logic ill);
    logic [31:0] ext;
    ext = {{20{im[11]}}, im};
    res = 0; sd = 0; ill = 0;
    case (op)
      4'd0: res = a + b;
      4'd1: res = a - b;
      4'd2: res = a * b;
      4'd3: begin
        if (b == 0) res = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = 32'h8000_0000;
        else res = $signed(a) / $signed(b);
      end
      4'd4: res = a + ext;
      4'd5: begin res = a + ext; sd = b; end
      default: ill = 1;
    endcase
  endtask

  task automatic model_step();
    logic ready;
    logic [31:0] dsd;
    logic dill;
    if (rst) begin
      m_valid = 0; m_op = 0; m_rd = 0; m_res = 0; m_sd = 0; m_ill = 0; m_div_left = 0;
      return;
    end
    ready = (m_div_left == 0) && (!m_valid || bus.out_ready);
    if (m_valid && bus.out_ready) m_valid = 0;
    if (m_div_left > 0) begin
      m_div_left--;
      if (m_div_left == 0) begin
        m_valid = 1; m_op = 4'd3; m_rd = p_rd; m_res = p_res; m_sd = 0; m_ill = 0;
      end
    end
    if (bus.in_valid && ready) begin
      if (bus.operation == 4'd3) begin
        m_div_left = 32;
        p_rd = bus.rd;
        calc(bus.operation, bus.rs1_val, bus.rs2_val, bus.imm, p_res, dsd, dill);
      end else begin
        m_valid = 1; m_op = bus.operation; m_rd = bus.rd;
        calc(bus.operation, bus.rs1_val, bus.rs2_val, bus.imm, m_res, m_sd, m_ill);
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // ---------------- compare process + result log ----------------
  logic [31:0] log_res[$], log_sd[$];
  logic        log_ill[$];
  int          log_cyc[$];
  logic        prev_hold = 0;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_out_result", bus.out_result, 0);
      check("rst_out_rd", bus.out_rd, 0);
      prev_hold = 0;
    end else begin
      check("in_ready", bus.in_ready,
            (m_div_left == 0) && (!m_valid || bus.out_ready));
      check("out_valid", bus.out_valid, m_valid);
      check("busy", bus.busy, m_div_left > 0);
      if (m_valid) begin
        check("out_op", bus.out_op, m_op);
        check("out_rd", bus.out_rd, m_rd);
        check("out_result", bus.out_result, m_res);
        check("out_store_data", bus.out_store_data, m_sd);
        check("out_illegal", bus.out_illegal, m_ill);
      end
      if (bus.out_valid && !prev_hold) begin
        log_res.push_back(bus.out_result);
        log_sd.push_back(bus.out_store_data);
        log_ill.push_back(bus.out_illegal);
        log_cyc.push_back(cyc);
      end
      prev_hold = bus.out_valid && !bus.out_ready;
    end
  end

  // ---------------- stimulus ----------------
  int acc[14];
  int rst_acc;

  // Returns the cycle number in which the operation was accepted (-1 on timeout).
  task automatic issue(input logic [3:0] op, input logic [4:0] r, input logic [31:0] a,
                       input logic [31:0] b, input logic [11:0] im, output int when);
    int n = 0;
    bus.in_valid = 1; bus.operation = op; bus.rd = r;
    bus.rs1_val = a; bus.rs2_val = b; bus.imm = im;
    when = -1;
    while (when < 0 && n < 200) begin
      @(negedge clk);
      if (bus.in_ready) when = cyc;
      n++;
    end
    if (when < 0) begin
      vectors++; miscompares++;
      $display("FAIL issue_timeout: op %0d never accepted", op);
    end
    @(posedge clk); #1;
    bus.in_valid = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int n_log;
    rst = 1;
    bus.in_valid = 0; bus.operation = 0; bus.rd = 0;
    bus.rs1_val = 0; bus.rs2_val = 0; bus.imm = 0; bus.out_ready = 1;
    repeat (3) @(posedge clk);
    #3 rst = 0;
    @(negedge clk);
    check("in_ready_after_reset", bus.in_ready, 1);
    @(posedge clk); #1;

    issue(4'd0, 5'd1, 32'd5, 32'd7, 12'd0, acc[0]);
    issue(4'd1, 5'd2, 32'd3, 32'd5, 12'd0, acc[1]);
    issue(4'd2, 5'd3, 32'h0000_FFFF, 32'h0001_0001, 12'd0, acc[2]);
    issue(4'd3, 5'd4, 32'hFFFF_FFF9, 32'd2, 12'd0, acc[3]);
    issue(4'd3, 5'd5, 32'd7, 32'd0, 12'd0, acc[4]);
    issue(4'd3, 5'd6, 32'h8000_0000, 32'hFFFF_FFFF, 12'd0, acc[5]);
    issue(4'd4, 5'd7, 32'h0000_1000, 32'd0, 12'hFFC, acc[6]);
    issue(4'd5, 5'd8, 32'h0000_0020, 32'hDEAD_BEEF, 12'h004, acc[7]);
    issue(4'd9, 5'd9, 32'd11, 32'd22, 12'h123, acc[8]);
    idle(3);

    // Stall the output for five cycles behind an ADD.
    bus.out_ready = 0;
    issue(4'd0, 5'd10, 32'd100, 32'd23, 12'd0, acc[9]);
    repeat (5) begin
      @(negedge clk);
      check("hold_in_ready", bus.in_ready, 0);
      check("hold_out_valid", bus.out_valid, 1);
      check("hold_out_result", bus.out_result, 32'd123);
      check("hold_out_rd", bus.out_rd, 5'd10);
    end
    @(posedge clk); #1;
    bus.out_ready = 1;
    issue(4'd1, 5'd11, 32'd50, 32'd8, 12'd0, acc[10]);
    idle(3);

    issue(4'd3, 5'd12, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 12'd0, acc[11]);
    issue(4'd3, 5'd13, 32'd100, 32'hFFFF_FFF9, 12'd0, acc[12]);
    idle(3);

    // Reset in the middle of a division.
    issue(4'd3, 5'd14, 32'd100, 32'd3, 12'd0, rst_acc);
    while (cyc < rst_acc + 10) @(negedge clk);
    @(posedge clk); #2;
    check("busy_before_abort", bus.busy, 1);
    rst = 1;
    #1;
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_in_ready", bus.in_ready, 0);
    check("abort_out_result", bus.out_result, 0);
    check("abort_out_op", bus.out_op, 0);
    check("abort_out_store_data", bus.out_store_data, 0);
    @(posedge clk); #3 rst = 0;
    @(negedge clk);
    check("abort_in_ready_release", bus.in_ready, 1);
    n_log = log_res.size();
    idle(40);
    check("no_stale_result", log_res.size(), n_log);

    issue(4'd0, 5'd1, 32'd1, 32'd1, 12'd0, acc[13]);
    idle(3);

    // Hand-computed literal expectations.
    check("log_count", log_res.size(), 14);
    if (log_res.size() >= 14) begin
      check("add_5_7", log_res[0], 32'd12);
      check("sub_3_5", log_res[1], 32'hFFFF_FFFE);
      check("mul_ffff_10001", log_res[2], 32'hFFFF_FFFF);
      check("div_m7_2", log_res[3], 32'hFFFF_FFFD);
      check("div_by_zero", log_res[4], 32'hFFFF_FFFF);
      check("div_overflow", log_res[5], 32'h8000_0000);
      check("load_addr", log_res[6], 32'h0000_0FFC);
      check("store_addr", log_res[7], 32'h0000_0024);
      check("store_data", log_sd[7], 32'hDEAD_BEEF);
      check("illegal_flag", log_ill[8], 1);
      check("illegal_result", log_res[8], 0);
      check("hold_add", log_res[9], 32'd123);
      check("drain_sub", log_res[10], 32'd42);
      check("div_neg_neg", log_res[11], 32'd14);
      check("div_pos_neg", log_res[12], 32'hFFFF_FFF2);
      check("add_after_reset", log_res[13], 32'd2);
      // Accept happens in cycle N; single-cycle results are seen in N+1,
      // division results 32 edges after the accepting edge, i.e. in N+33.
      for (int i = 0; i < 14; i++) begin
        if (i == 3 || i == 4 || i == 5 || i == 11 || i == 12)
          check($sformatf("div_latency_%0d", i), log_cyc[i] - acc[i], 33);
        else
          check($sformatf("latency_%0d", i), log_cyc[i] - acc[i], 1);
      end
      check("back_to_back_1", log_cyc[1] - log_cyc[0], 1);
      check("back_to_back_2", log_cyc[2] - log_cyc[1], 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/execute_unit.md
# execute_unit

Execute stage directly downstream of the instruction decoder. Accepts one decoded operation (4-bit operation code, destination register, both source operand values already read from the register file, and the 12-bit immediate) per valid/ready handshake. Computes ADD/SUB/MUL in one cycle, signed DIV over 32 cycles, and LOAD/STORE effective addresses. Presents a registered result to the memory/writeback stage behind a second valid/ready handshake.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  decoded operation present.
- in_ready  out  1  stage can accept this cycle (combinational).
- operation  in  4  0=ADD, 1=SUB, 2=MUL, 3=DIV, 4=LOAD, 5=STORE, 6..15 illegal.
- rd  in  5  destination register index.
- rs1_val  in  32  source operand 1.
- rs2_val  in  32  source operand 2 (store data for STORE).
- imm  in  12  immediate, two's complement.
- out_valid  out  1  result register holds a result.
- out_ready  in  1  downstream accepts the result.
- out_op  out  4  operation code of the result.
- out_rd  out  5  destination index of the result.
- out_result  out  32  ALU result or effective address.
- out_store_data  out  32  rs2_val for STORE, 0 otherwise.
- out_illegal  out  1  operation code was 6..15.
- busy  out  1  division in progress.

## Operation
- States: IDLE, DIV_RUN. Output register is separate, with its own out_valid flag.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !rst.
- Accept occurs when in_valid && in_ready at a rising edge. Operands are captured only on accept.
- ADD: rs1+rs2 mod 2^32. SUB: rs1-rs2 mod 2^32. MUL: low 32 bits of the product; identical for signed and unsigned.
- LOAD/STORE: out_result = rs1_val + sign_extend(imm) mod 2^32. STORE: out_store_data = rs2_val.
- Illegal codes: out_result=0, out_store_data=0, out_illegal=1. The transaction still completes normally.
- DIV uses signed operands and truncates toward zero:
  - Magnitudes are divided by a restoring 1-bit/cycle divider over 32 iterations. The quotient is negated if the operand signs differ.
  - Divide by zero gives 0xFFFFFFFF.
  - 0x80000000 / 0xFFFFFFFF gives 0x80000000.
  - Both special cases still take the full 32 cycles.
- DIV accept: IDLE → DIV_RUN, iteration counter = 31, busy=1. The counter decrements every cycle. At counter==0 the edge loads the output register, sets out_valid=1, and returns to IDLE.
- Output register: when out_valid && out_ready at an edge, out_valid clears unless a single-cycle accept on the same edge reloads it. Simultaneous drain and accept is legal and lossless.
- A DIV accept always leaves the output register empty or draining, so DIV completion never stalls.
- out_op/out_rd/out_result/out_store_data/out_illegal hold stable while out_valid && !out_ready.

## Timing
- Reset, asynchronous: state=IDLE, counter=0, busy=0, out_valid=0, out_op=0, out_rd=0, out_result=0, out_store_data=0, out_illegal=0. in_ready=0 while rst is high.
- Reset during DIV_RUN aborts the division. No result is ever produced for it.
- ADD/SUB/MUL/LOAD/STORE/illegal: out_valid is high in the cycle after the accepting edge (latency 1). Throughput is 1 per cycle when out_ready stays high.
- DIV: out_valid is high 32 cycles after the accepting edge. in_ready=0 and busy=1 for those 32 cycles. in_ready can return high in the same cycle that out_valid rises, if out_ready=1.
- No combinational path from in_valid to out_valid. The only combinational paths are out_ready→in_ready and rst→in_ready.

## Test plan
- Back-to-back ADD 5+7, SUB 3−5, MUL 0xFFFF×0x10001, with out_ready=1 → results 12, 0xFFFFFFFE, 0xFFFFFFFF on consecutive cycles, each one cycle after its accept.
- DIV −7/2, 7/0, 0x80000000/−1 → −3, 0xFFFFFFFF, 0x80000000. Each has out_valid exactly 32 cycles after accept and busy high throughout.
- LOAD rs1=0x1000, imm=0xFFC → out_result 0x0FFC. STORE rs1=0x20, imm=0x004, rs2=0xDEADBEEF → out_result 0x24, out_store_data 0xDEADBEEF.
- Hold out_ready=0 for 5 cycles after an ADD → in_ready=0 and outputs stable. Then out_ready=1 with a new SUB offered → drain and accept on the same edge, and the SUB result appears next cycle.
- Assert rst at cycle 10 of a DIV → all outputs 0 immediately. After release, in_ready=1 and no stale result appears.
- operation=9 → out_illegal=1, out_result=0, latency 1.
